// File: rtl/stage3_pkg.sv
// Shared types and constants for the stage-3 load/store unit: instruction
// decode constants, writeback select, FSM states and store-buffer entries.
package stage3_pkg;

  typedef enum logic [1:0] {
    WB_PC4 = 2'd0,
    WB_ALU = 2'd1,
    WB_MEM = 2'd2
  } wb_sel_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD
  } lsu_state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_B      = 3'b000;
  localparam logic [2:0] F3_H      = 3'b001;
  localparam logic [2:0] F3_W      = 3'b010;
  localparam logic [2:0] F3_BU     = 3'b100;
  localparam logic [2:0] F3_HU     = 3'b101;
  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRWI = 3'b101;

  typedef struct packed {
    logic [29:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } sb_entry_t;

  // Byte lanes touched by an access of size funct3 at byte offset off.
  function automatic logic [3:0] byte_mask(input logic [1:0] off, input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] off,
                                               input logic [2:0] f3);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (f3)
      F3_B:    return {{24{sh[7]}}, sh[7:0]};
      F3_H:    return {{16{sh[15]}}, sh[15:0]};
      F3_BU:   return {24'b0, sh[7:0]};
      F3_HU:   return {16'b0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

endpackage

// File: rtl/store_buffer.sv
// Circular store buffer with a parallel youngest-match search used for
// load hazard detection and store-to-load forwarding.
module store_buffer
  import stage3_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  sb_entry_t   push_entry,
  input  logic        pop,
  input  logic [29:0] lookup_addr,
  input  logic [3:0]  lookup_mask,
  output logic        full,
  output logic        empty,
  output sb_entry_t   head_entry,
  output logic        match,
  output logic        covered,
  output logic [31:0] fwd_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t      mem [DEPTH];
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic [CW-1:0]  count;
  sb_entry_t      youngest;

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign head_entry = mem[head];

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_entry;
  end

  // Walk oldest to youngest so the last hit left standing is the youngest.
  always_comb begin
    match    = 1'b0;
    youngest = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count) && (mem[head + PW'(i)].addr == lookup_addr)) begin
        match    = 1'b1;
        youngest = mem[head + PW'(i)];
      end
    end
  end

  assign covered  = match && ((youngest.mask & lookup_mask) == lookup_mask);
  assign fwd_data = youngest.data;

endmodule

// File: rtl/stage3_lsu.sv
// Memory/writeback stage: decodes the instruction, drives the data cache,
// buffers stores and produces the writeback value and stage stall.
module stage3_lsu
  import stage3_pkg::*;
#(
  parameter int SB_DEPTH = 4,
  parameter bit FWD_EN   = 1'b1,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic [31:0]       pc,
  input  logic [31:0]       alu_out,
  input  logic [31:0]       rs2d,
  input  logic [31:0]       inst,
  input  logic              jump,
  input  logic              stall_in,
  output logic [ADDR_W-1:0] dcache_addr,
  output logic              dcache_re,
  output logic [3:0]        dcache_we,
  output logic [31:0]       dcache_din,
  input  logic              dcache_ready,
  input  logic              dcache_rvalid,
  input  logic [31:0]       dcache_dout,
  output logic [31:0]       wb_data,
  output logic              wb_valid,
  output logic              rwe,
  output logic              csr_we,
  output logic              pc_sel,
  output logic              misaligned,
  output logic              stall_out
);

  lsu_state_e  state, state_next;
  logic [31:0] hold_data;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [1:0]  offset;
  logic        is_load, is_store, is_fence, is_csr, is_jump, writes_rd, misal;
  logic [3:0]  need_mask;
  logic [31:0] store_lane;
  wb_sel_e     wb_sel;
  logic        complete, push, pop, fwd_hit;
  logic [31:0] mem_data;
  sb_entry_t   push_entry, sb_head;
  logic        sb_full, sb_empty, sb_match, sb_covered;
  logic [31:0] sb_fwd_data;
  logic        unused_inst;

  assign opcode    = inst[6:0];
  assign funct3    = inst[14:12];
  assign offset    = alu_out[1:0];
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_fence  = (opcode == OP_FENCE);
  assign is_jump   = (opcode == OP_JAL) || (opcode == OP_JALR);
  assign is_csr    = (opcode == OP_SYSTEM) && ((funct3 == F3_CSRRW) || (funct3 == F3_CSRRWI));
  assign writes_rd = is_load || is_jump || is_csr || (opcode == OP_OP) || (opcode == OP_IMM) ||
                     (opcode == OP_LUI) || (opcode == OP_AUIPC);
  assign wb_sel    = is_jump ? WB_PC4 : (is_load ? WB_MEM : WB_ALU);
  assign misal     = (is_load || is_store) &&
                     (((funct3[1:0] == 2'b01) && offset[0]) ||
                      ((funct3[1:0] == 2'b10) && (offset != 2'b00)));
  assign need_mask = byte_mask(offset, funct3);
  assign unused_inst = ^{inst[31:15], inst[11:7]};

  always_comb begin
    case (funct3[1:0])
      2'b00:   store_lane = {24'b0, rs2d[7:0]} << {offset, 3'b000};
      2'b01:   store_lane = {16'b0, rs2d[15:0]} << {offset, 3'b000};
      default: store_lane = rs2d;
    endcase
  end

  assign push_entry = '{addr: alu_out[31:2], mask: need_mask, data: store_lane};
  assign fwd_hit    = FWD_EN && sb_match && sb_covered;
  assign push       = (state == S_IDLE) && valid && !stall_in && is_store && !misal && !sb_full;
  assign pop        = (state != S_ISSUE) && !sb_empty && dcache_ready;

  store_buffer #(.DEPTH(SB_DEPTH)) u_sb (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .lookup_addr(alu_out[31:2]),
    .lookup_mask(need_mask),
    .full       (sb_full),
    .empty      (sb_empty),
    .head_entry (sb_head),
    .match      (sb_match),
    .covered    (sb_covered),
    .fwd_data   (sb_fwd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      hold_data <= '0;
    end else begin
      state <= state_next;
      if ((state == S_WAIT) && dcache_rvalid && stall_in) hold_data <= dcache_dout;
    end
  end

  // complete means the instruction could retire now if stall_in allows it.
  always_comb begin
    state_next = state;
    complete   = 1'b0;
    mem_data   = '0;
    case (state)
      S_IDLE: begin
        if (valid) begin
          if (misal) begin
            complete = 1'b1;
          end else if (is_store) begin
            complete = !sb_full;
          end else if (is_load) begin
            if (fwd_hit) begin
              complete = 1'b1;
              mem_data = load_extract(sb_fwd_data, offset, funct3);
            end else if (!sb_match && !stall_in) begin
              state_next = S_ISSUE;
            end
          end else if (is_fence) begin
            complete = sb_empty;
          end else begin
            complete = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (dcache_ready) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (dcache_rvalid) begin
          if (stall_in) begin
            state_next = S_HOLD;
          end else begin
            complete   = 1'b1;
            mem_data   = load_extract(dcache_dout, offset, funct3);
            state_next = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        mem_data = load_extract(hold_data, offset, funct3);
        if (!stall_in) begin
          complete   = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign pc_sel = jump;

  always_comb begin
    dcache_re   = 1'b0;
    dcache_we   = '0;
    dcache_addr = '0;
    dcache_din  = '0;
    wb_valid    = 1'b0;
    wb_data     = '0;
    rwe         = 1'b0;
    csr_we      = 1'b0;
    misaligned  = 1'b0;
    stall_out   = 1'b0;
    if (!reset) begin
      if (state == S_ISSUE) begin
        dcache_re   = 1'b1;
        dcache_addr = ADDR_W'({alu_out[31:2], 2'b00});
      end else if (!sb_empty) begin
        dcache_we   = sb_head.mask;
        dcache_addr = ADDR_W'({sb_head.addr, 2'b00});
        dcache_din  = sb_head.data;
      end
      wb_valid   = valid && complete && !stall_in;
      stall_out  = valid && !complete;
      misaligned = valid && misal;
      rwe        = wb_valid && writes_rd && !misal;
      csr_we     = wb_valid && is_csr;
      case (wb_sel)
        WB_PC4:  wb_data = pc + 32'd4;
        WB_MEM:  wb_data = mem_data;
        default: wb_data = alu_out;
      endcase
    end
  end

endmodule

// File: tb/tb_stage3_lsu.sv
// Directed self-checking bench for stage3_lsu: forwarding, hazard stall,
// full buffer, load latency, misalignment, FENCE, stall_in hold and reset.
module tb_stage3_lsu;

  localparam logic [31:0] I_ADD   = 32'h0000_0033;
  localparam logic [31:0] I_JAL   = 32'h0000_006F;
  localparam logic [31:0] I_CSRRW = 32'h0000_1073;
  localparam logic [31:0] I_SB    = 32'h0000_0023;
  localparam logic [31:0] I_SH    = 32'h0000_1023;
  localparam logic [31:0] I_SW    = 32'h0000_2023;
  localparam logic [31:0] I_LH    = 32'h0000_1003;
  localparam logic [31:0] I_LW    = 32'h0000_2003;
  localparam logic [31:0] I_LBU   = 32'h0000_4003;
  localparam logic [31:0] I_FENCE = 32'h0000_000F;

  logic        clk = 1'b0;
  logic        reset, valid, jump, stall_in;
  logic [31:0] pc, alu_out, rs2d, inst;
  logic [31:0] dcache_addr, dcache_din, dcache_dout, wb_data;
  logic        dcache_re, dcache_ready, dcache_rvalid;
  logic [3:0]  dcache_we;
  logic        wb_valid, rwe, csr_we, pc_sel, misaligned, stall_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stage3_lsu #(.SB_DEPTH(4), .FWD_EN(1'b1), .ADDR_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .valid        (valid),
    .pc           (pc),
    .alu_out      (alu_out),
    .rs2d         (rs2d),
    .inst         (inst),
    .jump         (jump),
    .stall_in     (stall_in),
    .dcache_addr  (dcache_addr),
    .dcache_re    (dcache_re),
    .dcache_we    (dcache_we),
    .dcache_din   (dcache_din),
    .dcache_ready (dcache_ready),
    .dcache_rvalid(dcache_rvalid),
    .dcache_dout  (dcache_dout),
    .wb_data      (wb_data),
    .wb_valid     (wb_valid),
    .rwe          (rwe),
    .csr_we       (csr_we),
    .pc_sel       (pc_sel),
    .misaligned   (misaligned),
    .stall_out    (stall_out)
  );

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] addr,
                               input logic [31:0] data, input logic si, input logic rdy,
                               input logic rv, input logic [31:0] dout);
    @(negedge clk);
    valid         = v;
    inst          = ins;
    alu_out       = addr;
    rs2d          = data;
    stall_in      = si;
    dcache_ready  = rdy;
    dcache_rvalid = rv;
    dcache_dout   = dout;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; jump = 1'b1; pc = 32'h40;
    applyStimulus(1'b0, I_ADD, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("rst_wb_valid", wb_valid, 0);
    checkOutput("rst_stall", stall_out, 0);
    checkOutput("rst_re", dcache_re, 0);
    checkOutput("rst_we", dcache_we, 0);
    checkOutput("rst_pc_sel", pc_sel, 1);
    checkOutput("rst_wb_data", wb_data, 0);
    reset = 1'b0; jump = 1'b0;

    $display("[TB] non-memory instructions");
    applyStimulus(1'b1, I_ADD, 32'h1234, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("add_wb_valid", wb_valid, 1);
    checkOutput("add_wb_data", wb_data, 32'h1234);
    checkOutput("add_rwe", rwe, 1);
    checkOutput("add_csr_we", csr_we, 0);
    checkOutput("add_pc_sel", pc_sel, 0);
    jump = 1'b1;
    applyStimulus(1'b1, I_JAL, 32'h80, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("jal_wb_data", wb_data, 32'h44);
    checkOutput("jal_pc_sel", pc_sel, 1);
    jump = 1'b0;
    applyStimulus(1'b1, I_CSRRW, 32'h55, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("csr_we", csr_we, 1);
    checkOutput("csr_wb_valid", wb_valid, 1);

    $display("[TB] store-to-load forwarding");
    applyStimulus(1'b1, I_SW, 32'h100, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("sw_wb_valid", wb_valid, 1);
    checkOutput("sw_rwe", rwe, 0);
    checkOutput("sw_we_empty", dcache_we, 0);
    applyStimulus(1'b1, I_LW, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("fwd_wb_valid", wb_valid, 1);
    checkOutput("fwd_wb_data", wb_data, 32'hDEADBEEF);
    checkOutput("fwd_re", dcache_re, 0);
    checkOutput("fwd_stall", stall_out, 0);
    applyStimulus(1'b0, I_ADD, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("drain1_we", dcache_we, 4'hF);
    checkOutput("drain1_addr", dcache_addr, 32'h100);
    checkOutput("drain1_din", dcache_din, 32'hDEADBEEF);

    $display("[TB] partial-overlap hazard");
    applyStimulus(1'b1, I_SB, 32'h101, 32'h7F, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("sb_wb_valid", wb_valid, 1);
    checkOutput("sb_we_empty", dcache_we, 0);
    applyStimulus(1'b1, I_LW, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("haz_stall", stall_out, 1);
    checkOutput("haz_wb_valid", wb_valid, 0);
    checkOutput("haz_re", dcache_re, 0);
    checkOutput("haz_we", dcache_we, 4'b0010);
    checkOutput("haz_din", dcache_din, 32'h00007F00);
    applyStimulus(1'b1, I_LW, 32'h100, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("haz_pop_stall", stall_out, 1);
    applyStimulus(1'b1, I_LW, 32'h100, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("haz_clear_stall", stall_out, 1);
    checkOutput("haz_clear_we", dcache_we, 0);
    checkOutput("haz_clear_re", dcache_re, 0);
    applyStimulus(1'b1, I_LW, 32'h100, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("haz_issue_re", dcache_re, 1);
    checkOutput("haz_issue_addr", dcache_addr, 32'h100);
    applyStimulus(1'b1, I_LW, 32'h100, 32'h0, 1'b0, 1'b1, 1'b1, 32'h11223344);
    checkOutput("haz_rd_wb_valid", wb_valid, 1);
    checkOutput("haz_rd_wb_data", wb_data, 32'h11223344);
    checkOutput("haz_rd_rwe", rwe, 1);

    $display("[TB] LH with three-cycle latency");
    applyStimulus(1'b1, I_LH, 32'h102, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("lh_c0_stall", stall_out, 1);
    applyStimulus(1'b1, I_LH, 32'h102, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("lh_c1_stall", stall_out, 1);
    checkOutput("lh_c1_re", dcache_re, 1);
    checkOutput("lh_c1_addr", dcache_addr, 32'h100);
    applyStimulus(1'b1, I_LH, 32'h102, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("lh_c2_stall", stall_out, 1);
    checkOutput("lh_c2_re", dcache_re, 0);
    applyStimulus(1'b1, I_LH, 32'h102, 32'h0, 1'b0, 1'b1, 1'b1, 32'h80015555);
    checkOutput("lh_wb_valid", wb_valid, 1);
    checkOutput("lh_wb_data", wb_data, 32'hFFFF8001);
    checkOutput("lh_rwe", rwe, 1);
    checkOutput("lh_stall", stall_out, 0);

    $display("[TB] stall_in during WAIT");
    applyStimulus(1'b1, I_LBU, 32'h203, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, I_LBU, 32'h203, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("hold_issue_re", dcache_re, 1);
    applyStimulus(1'b1, I_LBU, 32'h203, 32'h0, 1'b1, 1'b1, 1'b1, 32'hAB000000);
    checkOutput("hold_rv_wb_valid", wb_valid, 0);
    applyStimulus(1'b1, I_LBU, 32'h203, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("hold_frozen_wb_valid", wb_valid, 0);
    applyStimulus(1'b1, I_LBU, 32'h203, 32'h0, 1'b0, 1'b1, 1'b0, 32'h12345678);
    checkOutput("hold_wb_valid", wb_valid, 1);
    checkOutput("hold_wb_data", wb_data, 32'h000000AB);

    $display("[TB] full store buffer");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, I_SW, 32'h200 + 32'(4 * k), 32'h1000 + 32'(k), 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput($sformatf("fill%0d_wb_valid", k), wb_valid, 1);
    end
    applyStimulus(1'b1, I_SW, 32'h210, 32'h1004, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("full_stall", stall_out, 1);
    checkOutput("full_wb_valid", wb_valid, 0);
    applyStimulus(1'b1, I_SW, 32'h210, 32'h1004, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("full_drain_stall", stall_out, 1);
    checkOutput("full_drain_addr", dcache_addr, 32'h200);
    applyStimulus(1'b1, I_SW, 32'h210, 32'h1004, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("full_enq_wb_valid", wb_valid, 1);
    checkOutput("full_enq_stall", stall_out, 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, I_ADD, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput($sformatf("drain%0d_addr", k), dcache_addr, 32'h204 + 32'(4 * k));
      checkOutput($sformatf("drain%0d_din", k), dcache_din, 32'h1001 + 32'(k));
    end
    applyStimulus(1'b0, I_ADD, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("drained_we", dcache_we, 0);

    $display("[TB] misaligned accesses");
    applyStimulus(1'b1, I_LW, 32'h103, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("mis_lw_flag", misaligned, 1);
    checkOutput("mis_lw_wb_valid", wb_valid, 1);
    checkOutput("mis_lw_rwe", rwe, 0);
    checkOutput("mis_lw_re", dcache_re, 0);
    applyStimulus(1'b1, I_SH, 32'h101, 32'hBEEF, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("mis_sh_flag", misaligned, 1);
    checkOutput("mis_after_lw_re", dcache_re, 0);
    applyStimulus(1'b0, I_ADD, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("mis_sh_no_enq", dcache_we, 0);

    $display("[TB] FENCE drain");
    applyStimulus(1'b1, I_SW, 32'h300, 32'hA, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, I_SW, 32'h304, 32'hB, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, I_FENCE, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("fence_c0_stall", stall_out, 1);
    applyStimulus(1'b1, I_FENCE, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("fence_c1_stall", stall_out, 1);
    checkOutput("fence_c1_addr", dcache_addr, 32'h300);
    applyStimulus(1'b1, I_FENCE, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("fence_c2_stall", stall_out, 1);
    checkOutput("fence_c2_addr", dcache_addr, 32'h304);
    applyStimulus(1'b1, I_FENCE, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("fence_done_stall", stall_out, 0);
    checkOutput("fence_done_wb_valid", wb_valid, 1);

    $display("[TB] reset during WAIT");
    applyStimulus(1'b1, I_LW, 32'h400, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, I_LW, 32'h400, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("rw_issue_re", dcache_re, 1);
    applyStimulus(1'b1, I_LW, 32'h400, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("rw_wait_stall", stall_out, 1);
    reset = 1'b1;
    applyStimulus(1'b0, I_ADD, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("rw_in_reset_wb_valid", wb_valid, 0);
    reset = 1'b0;
    applyStimulus(1'b0, I_ADD, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h55);
    checkOutput("rw_late_rv_wb_valid", wb_valid, 0);
    checkOutput("rw_late_rv_re", dcache_re, 0);
    applyStimulus(1'b1, I_FENCE, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h55);
    checkOutput("rw_empty_fence", wb_valid, 1);
    applyStimulus(1'b1, I_LW, 32'h500, 32'h0, 1'b0, 1'b0, 1'b1, 32'h66);
    checkOutput("rw_idle_wb_valid", wb_valid, 0);
    checkOutput("rw_idle_stall", stall_out, 1);
    applyStimulus(1'b1, I_LW, 32'h500, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("rw_reissue_re", dcache_re, 1);
    checkOutput("rw_reissue_addr", dcache_addr, 32'h500);
    applyStimulus(1'b1, I_LW, 32'h500, 32'h0, 1'b0, 1'b1, 1'b1, 32'h77);
    checkOutput("rw_final_wb_data", wb_data, 32'h77);
    applyStimulus(1'b0, I_ADD, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage3_lsu.md
Name: stage3_lsu

Overview:
- Parametrised successor to the pipeline's memory/writeback stage: computes writeback data, drives the data cache, and adds a DEPTH-entry store buffer that decouples stores from the cache.
- Loads are served by a request/valid cache handshake with variable latency, are forwarded from the store buffer when fully covered, and stall on partial overlap.
- Sits after the execute stage; its outputs feed regfile writeback, the PC select in stage 1 and the global stall.

Parameters:
- SB_DEPTH, 4, store-buffer entries; power of two, >= 2.
- FWD_EN, 1, 1 = store-to-load forwarding enabled; 0 = any address match stalls.
- ADDR_W, 32, dcache address width; data path fixed at 32 bits.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- valid  in  1  instruction in the stage is live
- pc  in  32  instruction PC
- alu_out  in  32  ALU result / effective address
- rs2d  in  32  store data
- inst  in  32  instruction word
- jump  in  1  branch/jump taken
- stall_in  in  1  external freeze; holds the instruction in the stage
- dcache_addr  out  ADDR_W  word-aligned request address
- dcache_re  out  1  read request
- dcache_we  out  4  byte write mask; nonzero = write request
- dcache_din  out  32  lane-aligned write data
- dcache_ready  in  1  cache accepts the request this cycle
- dcache_rvalid  in  1  read data valid
- dcache_dout  in  32  read data
- wb_data  out  32  writeback value
- wb_valid  out  1  instruction completes this cycle
- rwe  out  1  register write enable, qualified by wb_valid
- csr_we  out  1  CSR write enable, qualified by wb_valid
- pc_sel  out  1  equals jump
- misaligned  out  1  load/store address misaligned for its size
- stall_out  out  1  stage cannot complete this cycle

Behaviour:
- Reset: buffer empty (head = tail = 0, count = 0); FSM IDLE; all outputs 0 except pc_sel, which equals jump. A reset during LOAD_WAIT discards the outstanding read; a late rvalid is ignored.
- Decode: loads LB/LH/LW/LBU/LHU, stores SB/SH/SW, FENCE, CSRRW/CSRRWI.
- wb_sel: PC4 for JAL/JALR; MEM for loads; ALU for all others.
- csr_we: set for CSRRW/CSRRWI.
- Misalignment: halfword with addr[0] = 1, or word with addr[1:0] != 0.
  - Sets misaligned for the cycle.
  - No memory access, no enqueue.
  - Completes with wb_valid = 1, rwe = 0.
- Store:
  - Enqueues {addr[31:2], mask, data shifted to lane} when valid & !stall_in & count < SB_DEPTH. Completes the same cycle with wb_valid = 1 and rwe = 0.
  - A full buffer stalls the store, even if an entry drains that cycle. The store enqueues on the following cycle.
- Drain:
  - The head is issued as a write whenever no load request is being issued that cycle.
  - The head pops when dcache_ready = 1.
  - Drain continues while stall_in = 1.
- Load hazard check: compare the word address against all valid entries.
  - No match: the load issues.
  - Youngest match whose mask covers all needed bytes, with FWD_EN = 1: the load completes in the same cycle with wb_valid, without a cache access.
  - Otherwise: stall_out until no match remains; the drain proceeds meanwhile.
- FSM IDLE -> ISSUE -> WAIT:
  - ISSUE holds dcache_re until dcache_ready.
  - WAIT holds until dcache_rvalid.
  - The load completes in the rvalid cycle, with data extracted by offset and funct3 and sign- or zero-extended, then returns to IDLE.
  - Only one request is outstanding at a time.
- FENCE: stall_out until count = 0, then completes.
- stall_out: set while a store is blocked by a full buffer, during ISSUE, WAIT or the hazard stall, during a FENCE drain, or when a load is present without an immediate forward.
- Non-memory instructions complete in 0 cycles.
- stall_in gating: with stall_in = 1, no new enqueue or load issue and wb_valid = 0. An in-flight WAIT still captures rvalid into a hold register and completes once stall_in drops.
- Pointers wrap modulo SB_DEPTH.

Decomposition:
- Shared package stage3_pkg holds:
  - wb_sel encodings (PC4, ALU, MEM)
  - opcode and funct3 constants
  - the FSM state enum
  - the sb_entry_t struct {addr, mask, data}
- Sub-module store_buffer: circular FIFO with a parallel youngest-match and coverage search.

Test Plan:
- SW 0xDEADBEEF to 0x100, then LW 0x100 with FWD_EN = 1 -> wb_valid in the same cycle, wb_data = 0xDEADBEEF, no dcache_re.
- SB 0x7F to 0x101, then LW 0x100 -> stall_out until the entry drains (dcache_we = 4'b0010, din = 0x00007F00), then a cache read; wb_data comes from dcache_dout.
- 5 SWs with dcache_ready = 0 and SB_DEPTH = 4 -> 5th store stalls. When ready = 1, one entry pops and the 5th enqueues on the next cycle.
- LH 0x102 with dcache_dout = 0x8001xxxx and rvalid after 3 cycles -> stall_out for 3 cycles, wb_data = 0xFFFF8001, rwe = 1.
- LW 0x103 -> misaligned = 1, no dcache request, rwe = 0. FENCE with 2 buffered stores -> stall_out until count = 0.
- Reset asserted during WAIT, then rvalid -> no wb_valid, FSM IDLE, count = 0.
